// File: rtl/ram_arbiter_if.sv
// Requester, arbiter and RAM-side signals of ram_arbiter.
// err0/err1 exist only when RAM_ARB_ADDR_CHECK_EN is defined.
interface ram_arbiter_if #(
  parameter int unsigned N_BITS = 64,
  parameter int unsigned ADDR_W = 20
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [N_BITS-1:0] wdata0;
  logic [N_BITS-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [N_BITS-1:0] rdata;
  logic              ram_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [N_BITS-1:0] ram_wdata;
  logic [N_BITS-1:0] ram_rdata;
`ifdef RAM_ARB_ADDR_CHECK_EN
  logic              err0;
  logic              err1;
`endif

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
`ifdef RAM_ARB_ADDR_CHECK_EN
    output err0, err1,
`endif
    output gnt0, gnt1, done0, done1, rdata, ram_rw, ram_addr, ram_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
`ifdef RAM_ARB_ADDR_CHECK_EN
    input  err0, err1,
`endif
    input  gnt0, gnt1, done0, done1, rdata, ram_rw, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two requesters.
// Optional address range check: define RAM_ARB_ADDR_CHECK_EN.
module ram_arbiter #(
  parameter int unsigned N_BITS = 64,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned SIZE_N = 8
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [N_BITS-1:0] wdata;
  } cmd_t;

  if (SIZE_N < 1) begin : g_bad_size
    $error("ram_arbiter: SIZE_N must be at least 1");
  end

  state_e            state_q, state_d;
  logic              id_q, id_d;
  logic              last_gnt_q, last_gnt_d;
  logic              ram_rw_q, ram_rw_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [N_BITS-1:0] ram_wdata_q, ram_wdata_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              err_q, err_d;
  logic              winner;
  logic              addr_bad;
  logic              gnt0_c, gnt1_c;
  cmd_t              sel_cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      id_q        <= 1'b0;
      last_gnt_q  <= 1'b1;
      ram_rw_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      last_gnt_q  <= last_gnt_d;
      ram_rw_q    <= ram_rw_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    last_gnt_d  = last_gnt_q;
    ram_rw_d    = ram_rw_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err_d       = err_q;
    gnt0_c      = 1'b0;
    gnt1_c      = 1'b0;

    // Port 1 wins when alone, or on a tie when port 0 was granted last.
    winner = bus.req1 & (~bus.req0 | ~last_gnt_q);

    sel_cmd.we    = winner ? bus.we1    : bus.we0;
    sel_cmd.addr  = winner ? bus.addr1  : bus.addr0;
    sel_cmd.wdata = winner ? bus.wdata1 : bus.wdata0;

`ifdef RAM_ARB_ADDR_CHECK_EN
    addr_bad = (sel_cmd.addr >= ADDR_W'(SIZE_N));
`else
    addr_bad = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt0_c      = ~winner;
          gnt1_c      = winner;
          id_d        = winner;
          last_gnt_d  = winner;
          ram_rw_d    = sel_cmd.we & ~addr_bad;
          ram_addr_d  = sel_cmd.addr;
          ram_wdata_d = sel_cmd.wdata;
          err_d       = addr_bad;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ram_rw_d = 1'b0;
        done0_d  = ~id_q;
        done1_d  = id_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.gnt0      = gnt0_c;
  assign bus.gnt1      = gnt1_c;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.ram_rw    = ram_rw_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

  // RAM read data is forwarded only during the response cycle of a valid access.
  assign bus.rdata = ((state_q == S_RESP) && !err_q) ? bus.ram_rdata : '0;

`ifdef RAM_ARB_ADDR_CHECK_EN
  assign bus.err0 = done0_q & err_q;
  assign bus.err1 = done1_q & err_q;
`endif

endmodule
